adc_capture_ctrl: RTL
=====================

ADC_CAPTURE_CTRL -- requirements
Module: adc_capture_ctrl

Interface
REQ-001 Parameter NUM_SAMPLES, default 1024: samples written per capture; range 2..2^ADDR_W.
REQ-002 Parameter ADDR_W, default 10: buffer address width.
REQ-003 Parameter SETTLE_CYC, default 16: cycles discarded after arming, before trigger search.
REQ-004 Parameter TIMEOUT_CYC, default 35000: cycles in WAIT_TRIG before forced trigger; used only with REQ-030.
REQ-005 clk_35M  input  1  sample clock, same as ADC/DAC clock; the only clock.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 start  input  1  arm request, sampled each cycle.
REQ-008 abort  input  1  cancel capture, sampled each cycle.
REQ-009 ack  input  1  consumer has read the buffer.
REQ-010 trig_level  input  8  unsigned trigger threshold.
REQ-011 trig_edge  input  1  0 = rising crossing, 1 = falling crossing.
REQ-012 ad_data  input  8  unsigned ADC sample, one per clk_35M.
REQ-013 wr_en  output  1  buffer write strobe.
REQ-014 wr_addr  output  ADDR_W  buffer write address.
REQ-015 wr_data  output  8  buffer write data.
REQ-016 busy  output  1  high in ARM, WAIT_TRIG, CAPTURE.
REQ-017 done  output  1  high throughout DONE.
REQ-018 timed_out  output  1  last capture was forced by timeout.

Function
REQ-019 ad_data shall be registered twice every cycle (d_q, d_qq); d_qq_valid shall clear on entering WAIT_TRIG and set one cycle later.
REQ-020 States IDLE, ARM, WAIT_TRIG, CAPTURE, DONE; IDLE->ARM on start; ARM->WAIT_TRIG after SETTLE_CYC cycles in ARM.
REQ-021 Rising trigger: d_qq_valid, d_qq < trig_level and d_q >= trig_level; falling trigger: d_qq_valid, d_qq > trig_level and d_q <= trig_level.
REQ-022 On trigger in cycle t: state -> CAPTURE; in cycle t+1 wr_en=1, wr_addr=0, wr_data=d_q of cycle t (ad_data-to-wr_data latency 2 cycles).
REQ-023 In CAPTURE wr_en shall be high every cycle, wr_addr incrementing by 1, wr_data being consecutive samples, with no gaps.
REQ-024 After write NUM_SAMPLES-1, wr_en shall drop the next cycle and state -> DONE; exactly NUM_SAMPLES writes per capture; wr_addr shall never exceed NUM_SAMPLES-1.
REQ-025 DONE->IDLE on ack; ack outside DONE ignored; start outside IDLE ignored, including start and ack together in DONE (result IDLE, no re-arm).
REQ-026 abort in any state shall force IDLE next cycle with wr_en=0 and done=0; abort wins over start, trigger and ack in the same cycle; buffer contents undefined.
REQ-027 trig_level and trig_edge shall be read live each cycle in WAIT_TRIG; software holds them stable while busy.
REQ-028 wr_addr shall hold its last value when wr_en=0.

Reset
REQ-029 rst high at a clock edge shall, from any state including mid-CAPTURE: state=IDLE, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, timed_out=0, counters=0, d_q=d_qq=0, d_qq_valid=0; rst overrides all inputs.

Configuration
REQ-030 Macro ADC_TRIG_TIMEOUT_EN defined: a counter shall run in WAIT_TRIG; after TIMEOUT_CYC cycles with no trigger, a forced trigger shall occur exactly as in REQ-022 and timed_out shall set. timed_out shall clear on the next IDLE->ARM. A real trigger in the same cycle takes precedence, leaving timed_out=0.
REQ-031 Macro not defined: no timeout counter; WAIT_TRIG waits indefinitely; timed_out shall be tied 0.

Verification
REQ-032 Use NUM_SAMPLES=8 and SETTLE_CYC=4, ramp ad_data 0,10,20..., trig_level=45, trig_edge=0, pulse start. Required: busy rises the next cycle; first wr_en carries data 50 at addr 0; 8 contiguous writes 50..120 at addrs 0..7; then done=1 and busy=0.
REQ-033 Hold ad_data=200 for 100 cycles after arming, trig_level=100, trig_edge=1, then step ad_data to 90. Required: no write before the step; the first write has data 90.
REQ-034 Assert abort on the 4th CAPTURE write. Required: next cycle IDLE, wr_en=0, done never asserts; start then re-arms normally.
REQ-035 Pulse rst mid-CAPTURE, and separately give start together with ack in DONE. Required: after rst, all outputs are at reset values the next cycle; start+ack yields IDLE with busy=0.
REQ-036 Define ADC_TRIG_TIMEOUT_EN with TIMEOUT_CYC=50 and constant ad_data=7. Required: forced capture starts 50 cycles after WAIT_TRIG entry, timed_out=1, 8 writes of 7. Without the macro, no write occurs within 1000 cycles.

Source files
------------

// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl: arms on start, settles, waits for a level crossing and writes NUM_SAMPLES samples to a buffer.
// Defining ADC_TRIG_TIMEOUT_EN adds a forced trigger after TIMEOUT_CYC cycles in WAIT_TRIG.
module adc_capture_ctrl #(
  parameter int NUM_SAMPLES = 1024,
  parameter int ADDR_W      = 10,
  parameter int SETTLE_CYC  = 16,
  parameter int TIMEOUT_CYC = 35000
) (
  input  logic              clk_35M,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              ack,
  input  logic [7:0]        trig_level,
  input  logic              trig_edge,
  input  logic [7:0]        ad_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              done,
  output logic              timed_out
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ARM     = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  // One counter serves the settle phase and, when enabled, the trigger timeout.
  localparam int CNT_MAX = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST   = ADDR_W'(NUM_SAMPLES - 1);

  logic [2:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [7:0]        r_dq;
  logic [7:0]        r_dqq;
  logic              r_dqqValid;
  logic              r_wrEn;
  logic [ADDR_W-1:0] r_wrAddr;
  logic [7:0]        r_wrData;

  logic w_rise;
  logic w_fall;
  logic w_realTrig;
  logic w_timeout;
  logic w_trig;

  always_comb begin
    w_rise     = r_dqqValid && (r_dqq < trig_level) && (r_dq >= trig_level);
    w_fall     = r_dqqValid && (r_dqq > trig_level) && (r_dq <= trig_level);
    w_realTrig = (r_state == S_WAIT) && (trig_edge ? w_fall : w_rise);
    w_trig     = w_realTrig || w_timeout;
  end

  always_ff @(posedge clk_35M) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_dq       <= '0;
      r_dqq      <= '0;
      r_dqqValid <= 1'b0;
      r_wrEn     <= 1'b0;
      r_wrAddr   <= '0;
      r_wrData   <= '0;
    end else begin
      r_dq       <= ad_data;
      r_dqq      <= r_dq;
      // Low for the first WAIT_TRIG cycle, when d_qq still holds a pre-settle sample.
      r_dqqValid <= (r_state == S_WAIT);
      if (abort) begin
        r_state <= S_IDLE;
        r_wrEn  <= 1'b0;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_state <= S_ARM;
              r_cnt   <= '0;
            end
          end
          S_ARM: begin
            if (r_cnt == SETTLE_LAST) begin
              r_state <= S_WAIT;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_WAIT: begin
            if (w_trig) begin
              r_state  <= S_CAPTURE;
              r_cnt    <= '0;
              r_wrEn   <= 1'b1;
              r_wrAddr <= '0;
              r_wrData <= r_dq;
            end else begin
`ifdef ADC_TRIG_TIMEOUT_EN
              r_cnt <= r_cnt + 1'b1;
`else
              r_cnt <= r_cnt;
`endif
            end
          end
          S_CAPTURE: begin
            if (r_wrAddr == ADDR_LAST) begin
              r_state <= S_DONE;
              r_wrEn  <= 1'b0;
            end else begin
              r_wrAddr <= r_wrAddr + 1'b1;
              r_wrData <= r_dq;
            end
          end
          S_DONE: begin
            if (ack) begin
              r_state <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef ADC_TRIG_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic r_timedOut;

  assign w_timeout = (r_state == S_WAIT) && (r_cnt == TIMEOUT_LAST);

  // A real crossing in the timeout cycle wins, so the flag only marks truly forced captures.
  always_ff @(posedge clk_35M) begin
    if (rst) begin
      r_timedOut <= 1'b0;
    end else if (!abort) begin
      if ((r_state == S_IDLE) && start) begin
        r_timedOut <= 1'b0;
      end else if (w_timeout && !w_realTrig) begin
        r_timedOut <= 1'b1;
      end
    end
  end

  assign timed_out = r_timedOut;
`else
  assign w_timeout = 1'b0;
  assign timed_out = 1'b0;
`endif

  assign wr_en   = r_wrEn;
  assign wr_addr = r_wrAddr;
  assign wr_data = r_wrData;
  assign busy    = (r_state == S_ARM) || (r_state == S_WAIT) || (r_state == S_CAPTURE);
  assign done    = (r_state == S_DONE);

endmodule
